spi_slave_core: RTL and testbench

Mode-0 SPI slave (CPOL=0, CPHA=0, MSB first, 8-bit words) that sits between an external SPI master and the on-chip logic. All SPI pins are oversampled in the system clock domain. Each received byte is presented with a one-cycle valid strobe. A parallel transmit byte is shifted out on MISO at the same time. Several bytes may be exchanged within one chip-select frame.

---
 rtl/spi_slave_core.sv | 104 ++++++++++
 tb/tb_spi_slave_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// Mode-0 SPI slave: 8-bit MSB-first transfers, with all SPI pins oversampled in the clk domain.
// Each received byte gives a one-clk Rx_DV strobe while Tx_Byte is shifted out on MISO.
`timescale 1ns/1ps
module spi_slave_core (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPI_CS,
  input  logic       SPI_Clk,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       Rx_DV,
  output logic [7:0] Rx_Byte,
  input  logic [7:0] Tx_Byte
);

  logic [1:0] cs_sync_q,   cs_sync_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [6:0] rx_shift_q,  rx_shift_d;
  logic [6:0] tx_shift_q,  tx_shift_d;
  logic       miso_q,      miso_d;
  logic       rx_dv_q,     rx_dv_d;
  logic [7:0] rx_byte_q,   rx_byte_d;

  logic cs_n_sync;
  logic mosi_sync;
  logic sclk_rise;
  logic sclk_fall;

  // The third SPI_Clk stage holds the previous synchronized level, which gives the edge strobes.
  assign cs_n_sync = cs_sync_q[1];
  assign mosi_sync = mosi_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

  always_comb begin
    cs_sync_d   = {cs_sync_q[0], SPI_CS};
    sclk_sync_d = {sclk_sync_q[1:0], SPI_Clk};
    mosi_sync_d = {mosi_sync_q[0], SPI_MOSI};
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    rx_dv_d     = 1'b0;
    rx_byte_d   = rx_byte_q;

    if (cs_n_sync) begin
      bit_cnt_d  = 3'd0;
      rx_shift_d = 7'd0;
      tx_shift_d = 7'd0;
      miso_d     = 1'b0;
    end else begin
      // Between bytes MISO tracks the pending MSB, so it is valid before the first rise.
      if (bit_cnt_q == 3'd0) begin
        miso_d = Tx_Byte[7];
      end
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[5:0], mosi_sync};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd0) begin
          tx_shift_d = Tx_Byte[6:0];
        end
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d = {rx_shift_q, mosi_sync};
          rx_dv_d   = 1'b1;
        end
      end
      if (sclk_fall && (bit_cnt_q != 3'd0)) begin
        miso_d     = tx_shift_q[6];
        tx_shift_d = {tx_shift_q[5:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 3'd0;
      mosi_sync_q <= 2'd0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 7'd0;
      miso_q      <= 1'b0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= 8'h00;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
    end
  end

  assign SPI_MISO = miso_q;
  assign Rx_DV    = rx_dv_q;
  assign Rx_Byte  = rx_byte_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a directed SPI master sequence, with a receive-byte scoreboard
// checked by a monitor on every Rx_DV strobe.
`timescale 1ns/1ps
module tb_spi_slave_core;

  localparam int CLK_HALF = 20;
  localparam int SPI_HALF = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       SPI_CS;
  logic       SPI_Clk;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       Rx_DV;
  logic [7:0] Rx_Byte;
  logic [7:0] Tx_Byte;

  int checksTotal  = 0;
  int checksPassed = 0;
  int dvSeen       = 0;
  int dvExpected   = 0;
  int edgesSinceRise = 100;
  bit prevDv = 1'b0;
  logic [7:0] rxQueue[$];

  spi_slave_core dut (
    .clk      (clk),
    .reset    (reset),
    .SPI_CS   (SPI_CS),
    .SPI_Clk  (SPI_Clk),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .Rx_DV    (Rx_DV),
    .Rx_Byte  (Rx_Byte),
    .Tx_Byte  (Tx_Byte)
  );

  always #CLK_HALF clk = ~clk;

  // Shared comparison point for the stimulus sequence and the Rx_DV monitor.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checksTotal++;
    assert (obs === exp) begin
      checksPassed++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte slot as the master sees it: the master drives MOSI ahead of each rise and samples MISO at the rise.
  // The byte the slave should receive goes onto the scoreboard before any bit is sent.
  task automatic applyStimulus(input logic [7:0] mosiByte, input logic [7:0] expMiso);
    logic [7:0] got;
    got = 8'h00;
    rxQueue.push_back(mosiByte);
    dvExpected++;
    for (int i = 7; i >= 0; i--) begin
      SPI_MOSI = mosiByte[i];
      #SPI_HALF;
      SPI_Clk = 1'b1;
      got[i] = SPI_MISO;
      if (i == 0) edgesSinceRise = 0;
      #SPI_HALF;
      SPI_Clk = 1'b0;
    end
    checkOutput("master_rx_byte", {24'd0, got}, {24'd0, expMiso});
  endtask

  task automatic startFrame();
    SPI_CS = 1'b0;
    #SPI_HALF;
  endtask

  task automatic endFrame();
    #SPI_HALF;
    SPI_CS = 1'b1;
    #(2 * SPI_HALF);
  endtask

  // Monitor: checks Rx_DV width and latency, and pops the scoreboard to compare Rx_Byte.
  initial begin
    forever begin
      @(posedge clk);
      edgesSinceRise++;
      #1;
      if (prevDv) checkOutput("rx_dv_width", {31'd0, Rx_DV}, 32'd0);
      if (Rx_DV === 1'b1 && !prevDv) begin
        dvSeen++;
        checksTotal++;
        assert (edgesSinceRise >= 3 && edgesSinceRise <= 4) begin
          checksPassed++;
        end else begin
          $error("[TB] FAIL rx_dv_latency: observed %0d clk expected 3..4 clk", edgesSinceRise);
        end
        if (rxQueue.size() == 0) begin
          checkOutput("unexpected_rx_dv", {24'd0, Rx_Byte}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("rx_byte", {24'd0, Rx_Byte}, {24'd0, rxQueue.pop_front()});
        end
      end
      prevDv = (Rx_DV === 1'b1);
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    SPI_CS   = 1'b1;
    SPI_Clk  = 1'b0;
    SPI_MOSI = 1'b0;
    Tx_Byte  = 8'h00;
    repeat (4) @(negedge clk);
    checkOutput("reset_miso",    {31'd0, SPI_MISO}, 32'd0);
    checkOutput("reset_rx_dv",   {31'd0, Rx_DV},    32'd0);
    checkOutput("reset_rx_byte", {24'd0, Rx_Byte},  32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] single-byte frames");
    Tx_Byte = 8'hAA; startFrame(); applyStimulus(8'hC1, 8'hAA); endFrame();
    Tx_Byte = 8'hBE; startFrame(); applyStimulus(8'h33, 8'hBE); endFrame();
    Tx_Byte = 8'hEF; startFrame(); applyStimulus(8'h54, 8'hEF); endFrame();

    $display("[TB] back-to-back frames");
    Tx_Byte = 8'hEE; startFrame();
    applyStimulus(8'hA1, 8'hEE);
    Tx_Byte = 8'h1D;
    applyStimulus(8'h5C, 8'h1D);
    endFrame();
    Tx_Byte = 8'h25; startFrame();
    applyStimulus(8'h83, 8'h25);
    Tx_Byte = 8'h38;
    applyStimulus(8'h41, 8'h38);
    endFrame();

    $display("[TB] aborted byte");
    Tx_Byte = 8'h96;
    startFrame();
    for (int i = 0; i < 4; i++) begin
      SPI_MOSI = i[0];
      #SPI_HALF; SPI_Clk = 1'b1;
      #SPI_HALF; SPI_Clk = 1'b0;
    end
    endFrame();
    checkOutput("abort_rx_byte_held", {24'd0, Rx_Byte}, 32'h41);
    startFrame(); applyStimulus(8'h3C, 8'h96); endFrame();

    $display("[TB] reset mid-frame");
    Tx_Byte = 8'hFF;
    startFrame();
    for (int i = 0; i < 4; i++) begin
      SPI_MOSI = 1'b1;
      #SPI_HALF; SPI_Clk = 1'b1;
      #SPI_HALF; SPI_Clk = 1'b0;
    end
    #SPI_HALF;
    reset = 1'b1;
    #1;
    checkOutput("midreset_miso",    {31'd0, SPI_MISO}, 32'd0);
    checkOutput("midreset_rx_dv",   {31'd0, Rx_DV},    32'd0);
    checkOutput("midreset_rx_byte", {24'd0, Rx_Byte},  32'd0);
    SPI_CS = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    Tx_Byte = 8'h5A; startFrame(); applyStimulus(8'hC3, 8'h5A); endFrame();

    repeat (10) @(negedge clk);
    checkOutput("rx_dv_count",    dvSeen,         dvExpected);
    checkOutput("scoreboard_left", rxQueue.size(), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
